dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Data-memory access controller between the single-cycle MIPS data port and a slow SRAM backend.
//  Core side: active-low chip/write/output enables (CEN/WEN/OEN), word address A, write data D.
//  Backend side: variable-latency req/ack memory.
//  Stalls the core while an access is in flight; returns read data on ReadDataMem.
//  Optional one-entry posted-write buffer.
// PARAMETERS
//  AW       7    word-address width (matches core A[6:0])
//  DW       32   data width
//  TIMEOUT  16   max cycles waiting for mem_ack before abort; 0 = never time out
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  CEN          in   1   core chip enable, 0 = access requested this cycle
//  WEN          in   1   core write enable, 0 = write, 1 = read
//  OEN          in   1   core output enable, 0 = drive read data
//  A            in   AW  core word address
//  D            in   DW  core write data
//  ReadDataMem  out  DW  read data to core
//  stall        out  1   1 = core must hold PC and all data-port inputs stable
//  err          out  1   sticky timeout flag
//  mem_req      out  1   backend request, held until ack
//  mem_we       out  1   backend write, 1 = write
//  mem_addr     out  AW  backend address
//  mem_wdata    out  DW  backend write data
//  mem_rdata    in   DW  backend read data, valid with mem_ack
//  mem_ack      in   1   backend completion, single-cycle pulse
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_q=0, err=0, tcnt=0.
//   - stall forced 0; ReadDataMem=0.
//  FSM states IDLE, REQ, DONE (+ DRAIN with posted writes):
//   - IDLE:  CEN=0 -> stall=1 (combinational, same cycle); latch A/D/~WEN into mem_addr/mem_wdata/mem_we;
//            assert mem_req next edge; go to REQ. CEN=1 -> stay, stall=0.
//   - REQ:   mem_req=1, stall=1; tcnt increments each cycle.
//            mem_ack=1 -> capture mem_rdata into rdata_q (reads only), drop mem_req, go to DONE.
//            TIMEOUT!=0 and tcnt==TIMEOUT-1 with no ack -> drop mem_req, rdata_q=32'hDEADBEEF, err<=1, go to DONE.
//   - DONE:  stall=0 for exactly one cycle (core commits at this edge); next edge -> IDLE, tcnt=0.
//  Latency: min 2 stall cycles (ack in first REQ cycle); access completes in cycle 3.
//  ReadDataMem = rdata_q when OEN=0 and state==DONE, else 0.
//  Boundary rules:
//   - mem_ack outside REQ is ignored.
//   - ack and timeout in same cycle -> ack wins, err unchanged.
//   - reset mid-REQ: mem_req drops immediately (async), no write retried.
//   - address wrap: A=7'h7F handled like any other address, no increment logic.
//   - err clears only on reset.
//   - core inputs are sampled only in IDLE; changes in REQ/DONE are ignored.
// CONFIGURATION
//  DMEM_POSTED_WRITE_EN defined:
//   - Write in IDLE: latched, stall=0 in the same cycle; state -> DRAIN with mem_req=1, mem_we=1.
//   - DRAIN: on ack -> IDLE. Timeout follows REQ rules (err set, no retry).
//   - Any CEN=0 during DRAIN: stall=1 until drain completes; the new access then starts from IDLE normally.
//   - Reads follow REQ/DONE unchanged.
//  Not defined:
//   - Writes use IDLE->REQ->DONE exactly as reads (stalling); DRAIN state absent.
// TESTING
//  1. Read, ack after 1 cycle: A=7'h05, WEN=1, mem_rdata=32'h1234_5678 -> stall high 2 cycles; DONE cycle ReadDataMem=32'h12345678.
//  2. Write, ack after 4 cycles: A=7'h10, D=32'hCAFE_0001 ->
//     mem_addr=10, mem_we=1, mem_wdata=CAFE0001 held 4 cycles; stall 5 cycles; then DONE (no macro).
//  3. Timeout: TIMEOUT=16, no ack -> mem_req high exactly 16 cycles; err=1; ReadDataMem=32'hDEADBEEF in DONE; err stays 1.
//  4. Ack in same cycle as timeout expiry -> data captured, err=0.
//  5. Reset asserted mid-REQ -> mem_req=0 and stall=0 immediately.
//     After release, CEN=1 -> IDLE; stray mem_ack ignored.
//  6. DMEM_POSTED_WRITE_EN: write then read next cycle -> write stall=0; read stall=1 until drain ack, then normal read latency.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: stalls the single-cycle core while a req/ack SRAM access is in flight.
// Optional one-entry posted-write buffer enabled by defining DMEM_POSTED_WRITE_EN.
module dmem_access_ctrl #(
    parameter int AW      = 7,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] ReadDataMem,
    output logic          stall,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCW-1:0] TLAST    = TCW'(TIMEOUT - 1);
    localparam logic [DW-1:0]  ABORT_RD = DW'(32'hDEADBEEF);

`ifdef DMEM_POSTED_WRITE_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    state_t         state_q, state_d;
    logic [DW-1:0]  rdata_q;
    logic [TCW-1:0] tcnt_q;
    logic           start, in_flight, ack_hit, timeout_hit, finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        start     = 1'b0;
        in_flight = (state_q == REQ);
`ifdef DMEM_POSTED_WRITE_EN
        in_flight = in_flight || (state_q == DRAIN);
`endif
        // An ack arriving together with the last timeout cycle wins.
        ack_hit     = in_flight && mem_ack;
        timeout_hit = in_flight && (TIMEOUT != 0) && (tcnt_q == TLAST) && !mem_ack;
        finish      = ack_hit || timeout_hit;
        case (state_q)
            IDLE: begin
                if (!CEN) begin
                    start = 1'b1;
`ifdef DMEM_POSTED_WRITE_EN
                    if (!WEN) begin
                        state_d = DRAIN;
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                    end
`else
                    stall   = 1'b1;
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                stall = 1'b1;
                if (finish) state_d = DONE;
            end
            DONE: state_d = IDLE;
`ifdef DMEM_POSTED_WRITE_EN
            DRAIN: begin
                // A new access waits here until the buffered write has left.
                stall = !CEN;
                if (finish) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (!rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            err       <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            if (start) begin
                mem_addr  <= A;
                mem_wdata <= D;
                mem_we    <= ~WEN;
                mem_req   <= 1'b1;
            end else if (finish) begin
                mem_req <= 1'b0;
            end
            if (ack_hit && !mem_we) rdata_q <= mem_rdata;
            else if (timeout_hit)   rdata_q <= ABORT_RD;
            if (timeout_hit) err <= 1'b1;
            if (in_flight && !finish) tcnt_q <= tcnt_q + 1'b1;
            else                      tcnt_q <= '0;
        end
    end

    assign ReadDataMem = (!OEN && state_q == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: reads, stalled writes, timeout, reset mid-access, optional posted write.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CEN, WEN, OEN;
    logic [6:0]  A;
    logic [31:0] D;
    logic [31:0] ReadDataMem;
    logic        stall, err, mem_req, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int total = 0;
    int fails = 0;

    dmem_access_ctrl #(.AW(7), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D),
        .ReadDataMem(ReadDataMem), .stall(stall), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; CEN = 1'b0; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #13;
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", ReadDataMem, 0);
        CEN = 1'b1;
        #10 rst_n = 1'b1;
        cyc();
        chk("idle_stall", stall, 0);

        // Test 1: read, ack in first REQ cycle
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'h05;
        #1 chk("t1_stall_idle", stall, 1);
        cyc();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 7'h05);
        chk("t1_we", mem_we, 0);
        chk("t1_stall_req", stall, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        cyc();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("t1_done_stall", stall, 0);
        chk("t1_done_req", mem_req, 0);
        chk("t1_done_data", ReadDataMem, 32'h1234_5678);
        CEN = 1'b1;
        cyc();
        chk("t1_idle_data", ReadDataMem, 0);

`ifndef DMEM_POSTED_WRITE_EN
        // Test 2: write, ack after 4 cycles, stalling path
        CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = 7'h10; D = 32'hCAFE_0001;
        #1 chk("t2_stall_idle", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("t2_req", mem_req, 1);
            chk("t2_we", mem_we, 1);
            chk("t2_addr", mem_addr, 7'h10);
            chk("t2_wdata", mem_wdata, 32'hCAFE_0001);
            chk("t2_stall", stall, 1);
            if (i == 4) mem_ack = 1'b1;
        end
        cyc();
        mem_ack = 1'b0;
        chk("t2_done_stall", stall, 0);
        chk("t2_done_req", mem_req, 0);
        CEN = 1'b1; WEN = 1'b1;
        cyc();
        chk("t2_idle_stall", stall, 0);
`endif

        // Test 3: timeout on top address, no ack
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'h7F;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("t3_req", mem_req, 1);
        end
        chk("t3_addr", mem_addr, 7'h7F);
        chk("t3_err_before", err, 0);
        cyc();
        chk("t3_req_dropped", mem_req, 0);
        chk("t3_err", err, 1);
        chk("t3_abort_data", ReadDataMem, 32'hDEAD_BEEF);
        chk("t3_done_stall", stall, 0);
        CEN = 1'b1;
        cyc();
        cyc();
        chk("t3_err_sticky", err, 1);

        // Test 5: reset mid-REQ, then stray ack in IDLE
        CEN = 1'b0; WEN = 1'b0; A = 7'h21; D = 32'h0BAD_F00D;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t5_req_async", mem_req, 0);
        chk("t5_stall_async", stall, 0);
        chk("t5_err_cleared", err, 0);
        CEN = 1'b1; WEN = 1'b1;
        #10 rst_n = 1'b1;
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        cyc();
        mem_ack = 1'b0;
        chk("t5_stray_req", mem_req, 0);
        chk("t5_stray_stall", stall, 0);
        chk("t5_stray_data", ReadDataMem, 0);
        cyc();
        chk("t5_stray_data2", ReadDataMem, 0);

        // Test 4: ack on the timeout cycle, inputs changing during REQ
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'h22;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            A = 7'h33;
            if (i == 16) begin
                mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F;
            end
        end
        chk("t4_addr_held", mem_addr, 7'h22);
        cyc();
        mem_ack = 1'b0;
        chk("t4_data", ReadDataMem, 32'hA5A5_0F0F);
        chk("t4_err", err, 0);
        chk("t4_req", mem_req, 0);
        CEN = 1'b1;
        cyc();

`ifdef DMEM_POSTED_WRITE_EN
        // Test 6: posted write followed by a read
        CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = 7'h03; D = 32'h0000_0011;
        #1 chk("t6_wr_stall", stall, 0);
        cyc();
        chk("t6_drain_req", mem_req, 1);
        chk("t6_drain_we", mem_we, 1);
        WEN = 1'b1; OEN = 1'b0; A = 7'h04;
        #1 chk("t6_rd_stall0", stall, 1);
        cyc();
        chk("t6_rd_stall1", stall, 1);
        cyc();
        chk("t6_rd_stall2", stall, 1);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("t6_idle_stall", stall, 1);
        chk("t6_idle_req", mem_req, 0);
        cyc();
        chk("t6_rd_addr", mem_addr, 7'h04);
        chk("t6_rd_we", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        cyc();
        mem_ack = 1'b0;
        chk("t6_rd_data", ReadDataMem, 32'h0000_0077);
        chk("t6_rd_done_stall", stall, 0);
        CEN = 1'b1;
        cyc();
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
